// File: rtl/atmos_light_est_if.sv
// Pixel-stream input and atmospheric-light output bundle for atmos_light_est.
interface atmos_light_est_if;
    logic [7:0] I_R;
    logic [7:0] I_G;
    logic [7:0] I_B;
    logic       input_is_valid;
    logic       i_sof;
    logic [7:0] A_R;
    logic [7:0] A_G;
    logic [7:0] A_B;
    logic       o_valid;

    modport master (
        output I_R, I_G, I_B, input_is_valid, i_sof,
        input  A_R, A_G, A_B, o_valid
    );

    modport slave (
        input  I_R, I_G, I_B, input_is_valid, i_sof,
        output A_R, A_G, A_B, o_valid
    );
endinterface

// File: rtl/atmos_light_est.sv
// Atmospheric light estimator: per frame, keeps the RGB of the earliest pixel with the
// largest dark-channel value min(R,G,B) and publishes it when the frame completes.
module atmos_light_est #(
    parameter int IMG_WIDTH  = 512,
    parameter int IMG_HEIGHT = 512
) (
    input  logic             clk,
    input  logic             rst,
    atmos_light_est_if.slave bus
);
    localparam int NPIX = IMG_WIDTH * IMG_HEIGHT;
    localparam int CW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(NPIX - 1);

    typedef enum logic [0:0] {
        WAIT_FRAME = 1'b0,
        ACCUM      = 1'b1
    } state_t;

    function automatic logic [7:0] min3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        logic [7:0] m;
        m = (a < b) ? a : b;
        return (m < c) ? m : c;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, idx_s;
    logic          first_s, last_s;

    logic          s1_valid_q, s1_first_q, s1_last_q;
    logic [7:0]    s1_r_q, s1_g_q, s1_b_q, s1_dark_q;

    logic [7:0]    cand_r_q, cand_g_q, cand_b_q, cand_dark_q;
    logic          take_s, s2_last_q;

    logic [7:0]    a_r_q, a_g_q, a_b_q;
    logic          o_valid_q;

    // Pixel index (i_sof forces index 0), frame flags, next counter and FSM state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_s   = cnt_q;
        first_s = 1'b0;
        last_s  = 1'b0;
        if (bus.i_sof) begin
            idx_s = {CW{1'b0}};
        end else begin
            idx_s = cnt_q;
        end
        first_s = (idx_s == {CW{1'b0}}) || (state_q == WAIT_FRAME);
        last_s  = (idx_s == LAST_IDX);
        if (bus.input_is_valid) begin
            if (last_s) begin
                cnt_d = {CW{1'b0}};
            end else begin
                cnt_d = idx_s + CW'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        case (state_q)
            WAIT_FRAME: begin
                if (bus.input_is_valid) begin
                    state_d = ACCUM;
                end else begin
                    state_d = WAIT_FRAME;
                end
            end
            ACCUM:   state_d = ACCUM;
            default: state_d = WAIT_FRAME;
        endcase
    end

    // Stage 1: frame position tracking and pixel/dark-value register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= WAIT_FRAME;
            cnt_q      <= {CW{1'b0}};
            s1_valid_q <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_r_q     <= 8'd0;
            s1_g_q     <= 8'd0;
            s1_b_q     <= 8'd0;
            s1_dark_q  <= 8'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= bus.input_is_valid;
            s1_first_q <= first_s;
            s1_last_q  <= last_s;
            s1_r_q     <= bus.I_R;
            s1_g_q     <= bus.I_G;
            s1_b_q     <= bus.I_B;
            s1_dark_q  <= min3(bus.I_R, bus.I_G, bus.I_B);
        end
    end

    // Strictly-greater replacement keeps the earliest pixel on ties
    always_comb begin
        take_s = 1'b0;
        if (s1_valid_q) begin
            take_s = s1_first_q || (s1_dark_q > cand_dark_q);
        end else begin
            take_s = 1'b0;
        end
    end

    // Stage 2: candidate update and end-of-frame marker
    always_ff @(posedge clk) begin
        if (rst) begin
            cand_r_q    <= 8'd0;
            cand_g_q    <= 8'd0;
            cand_b_q    <= 8'd0;
            cand_dark_q <= 8'd0;
            s2_last_q   <= 1'b0;
        end else begin
            if (take_s) begin
                cand_r_q    <= s1_r_q;
                cand_g_q    <= s1_g_q;
                cand_b_q    <= s1_b_q;
                cand_dark_q <= s1_dark_q;
            end
            s2_last_q <= s1_valid_q && s1_last_q;
        end
    end

    // Output register: publish the finished frame's candidate with a one-cycle pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            a_r_q     <= 8'd0;
            a_g_q     <= 8'd0;
            a_b_q     <= 8'd0;
            o_valid_q <= 1'b0;
        end else begin
            o_valid_q <= s2_last_q;
            if (s2_last_q) begin
                a_r_q <= cand_r_q;
                a_g_q <= cand_g_q;
                a_b_q <= cand_b_q;
            end
        end
    end

    assign bus.A_R     = a_r_q;
    assign bus.A_G     = a_g_q;
    assign bus.A_B     = a_b_q;
    assign bus.o_valid = o_valid_q;
endmodule

// File: tb/tb_atmos_light_est.sv
// Bench for atmos_light_est on a 4x2 frame: directed vector table plus randomized traffic
// checked against a frame-buffer reference model.
module tb_atmos_light_est;
    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

    logic clk = 1'b0;
    logic rst;
    atmos_light_est_if bus();

    atmos_light_est #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: buffer the frame, pick max dark value at the end
    typedef struct {
        int          t;
        logic [23:0] a;
    } pend_t;

    logic [23:0] mframe[$];
    pend_t       pend[$];
    int          step_no  = 0;
    logic        m_ov;
    logic [23:0] m_a      = 24'h0;
    int          m_pulses = 0;
    int          d_pulses = 0;

    function automatic int dark(input logic [23:0] p);
        int r, g, b, m;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        m = (r < g) ? r : g;
        return (m < b) ? m : b;
    endfunction

    task automatic model_step(input logic rs, input logic vl, input logic sf, input logic [23:0] rgb);
        logic [23:0] best;
        int bd;
        m_ov = 1'b0;
        if (rs) begin
            mframe.delete();
            pend.delete();
            m_a = 24'h0;
        end else begin
            if (pend.size() > 0 && pend[0].t == step_no) begin
                m_ov = 1'b1;
                m_a  = pend[0].a;
                void'(pend.pop_front());
                m_pulses++;
            end
            if (vl) begin
                if (sf) mframe.delete();
                mframe.push_back(rgb);
                if (mframe.size() == NPIX) begin
                    bd   = -1;
                    best = 24'h0;
                    foreach (mframe[k]) begin
                        if (dark(mframe[k]) > bd) begin
                            bd   = dark(mframe[k]);
                            best = mframe[k];
                        end
                    end
                    pend.push_back('{t: step_no + 2, a: best});
                    mframe.delete();
                end
            end
        end
    endtask

    // One clock: drive at negedge, advance model, sample #1 after the rising edge
    task automatic step(input logic rs, input logic vl, input logic sf, input logic [23:0] rgb);
        @(negedge clk);
        rst                = rs;
        bus.input_is_valid = vl;
        bus.i_sof          = sf;
        {bus.I_R, bus.I_G, bus.I_B} = rgb;
        step_no++;
        model_step(rs, vl, sf, rgb);
        @(posedge clk);
        #1;
        if (bus.o_valid === 1'b1) d_pulses++;
        check($sformatf("model o_valid step %0d", step_no), 32'(bus.o_valid), 32'(m_ov));
        check($sformatf("model A step %0d", step_no), 32'({bus.A_R, bus.A_G, bus.A_B}), 32'(m_a));
    endtask

    // ---------------- directed vector table
    typedef struct {
        logic        rs;
        logic        vl;
        logic        sf;
        logic [23:0] rgb;
        logic        ov;
        logic [23:0] a;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [23:0] px(input int r, input int g, input int b);
        return {8'(r), 8'(g), 8'(b)};
    endfunction

    task automatic add(input logic rs, input logic vl, input logic sf, input logic [23:0] rgb);
        vec_t v;
        v.rs = rs; v.vl = vl; v.sf = sf; v.rgb = rgb; v.ov = 1'b0; v.a = 24'h0;
        tbl.push_back(v);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) add(1'b0, 1'b0, 1'b0, 24'h0);
    endtask

    task automatic pulse_at(input int idx, input logic [23:0] a);
        vec_t v;
        v = tbl[idx];
        v.ov = 1'b1;
        v.a  = a;
        tbl[idx] = v;
    endtask

    task automatic frame(input logic [23:0] base, input int sp, input logic [23:0] spv,
                         input logic sof0, output int last_i);
        for (int i = 0; i < NPIX; i++)
            add(1'b0, 1'b1, (i == 0) ? sof0 : 1'b0, (i == sp) ? spv : base);
        last_i = tbl.size() - 1;
    endtask

    initial begin
        int li, l1, l2;
        logic [23:0] a_hold;
        vec_t v;

        rst = 1'b1;
        bus.input_is_valid = 1'b0;
        bus.i_sof = 1'b0;
        bus.I_R = 8'd0; bus.I_G = 8'd0; bus.I_B = 8'd0;

        // reset, then release with o_valid still low
        add(1'b1, 1'b0, 1'b0, 24'h0);
        add(1'b1, 1'b0, 1'b0, 24'h0);
        idle(2);
        // single bright pixel
        frame(px(50, 60, 70), 5, px(200, 180, 190), 1'b0, li);
        idle(3);
        pulse_at(li + 2, px(200, 180, 190));
        // tie on dark value: earliest pixel wins
        for (int i = 0; i < NPIX; i++)
            add(1'b0, 1'b1, 1'b0, (i == 1) ? px(150, 150, 160) :
                                  (i == 6) ? px(170, 150, 150) : px(100, 120, 130));
        li = tbl.size() - 1;
        idle(3);
        pulse_at(li + 2, px(150, 150, 160));
        // bubbles, including an i_sof without valid that must be ignored
        for (int i = 0; i < NPIX; i++) begin
            add(1'b0, 1'b1, 1'b0, (i == 5) ? px(200, 180, 190) : px(50, 60, 70));
            if (i == 2) begin
                add(1'b0, 1'b0, 1'b1, px(255, 255, 255));
                idle(2);
            end
            if (i == 6) idle(3);
        end
        li = tbl.size() - 1;
        idle(3);
        pulse_at(li + 2, px(200, 180, 190));
        // i_sof mid-frame discards the partial frame
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, px(250, 250, 250));
        frame(px(20, 30, 40), 4, px(90, 80, 70), 1'b1, li);
        idle(3);
        pulse_at(li + 2, px(90, 80, 70));
        // reset mid-frame clears the estimate
        for (int i = 0; i < 5; i++) add(1'b0, 1'b1, 1'b0, px(230, 220, 210));
        add(1'b1, 1'b0, 1'b0, 24'h0);
        frame(px(33, 44, 55), 2, px(120, 110, 100), 1'b0, li);
        idle(3);
        pulse_at(li + 2, px(120, 110, 100));
        // back-to-back frames, the second darker than the first
        frame(px(5, 5, 5), 3, px(240, 230, 250), 1'b0, l1);
        frame(px(10, 20, 30), 0, px(10, 20, 30), 1'b1, l2);
        idle(3);
        pulse_at(l1 + 2, px(240, 230, 250));
        pulse_at(l2 + 2, px(10, 20, 30));

        // A holds its last published value between pulses; reset returns it to zero
        a_hold = 24'h0;
        for (int i = 0; i < tbl.size(); i++) begin
            v = tbl[i];
            if (v.rs) a_hold = 24'h0;
            else if (v.ov) a_hold = v.a;
            v.a = a_hold;
            tbl[i] = v;
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rs, tbl[i].vl, tbl[i].sf, tbl[i].rgb);
            check($sformatf("vec%0d o_valid", i), 32'(bus.o_valid), 32'(tbl[i].ov));
            check($sformatf("vec%0d A", i), 32'({bus.A_R, bus.A_G, bus.A_B}), 32'(tbl[i].a));
        end

        // randomized traffic with ties, zero dark values, bubbles, stray i_sof and resets
        for (int n = 0; n < 3000; n++) begin
            step(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0,
                 {8'($urandom_range(0, 15) * 17), 8'($urandom_range(0, 15) * 17),
                  8'($urandom_range(0, 15) * 17)});
        end
        idle(0);
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, 24'h0);
        check("pulse count", 32'(d_pulses), 32'(m_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
